// File: rtl/mem_access_unit.sv
// MEM-stage data-bus access unit: one request per load/store, with alignment checks,
// store lane replication and load extraction. Flow: IDLE -> REQ -> (WAIT) -> DONE, plus DRAIN after a flush.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_except,
    input  logic        mem_flush,
    input  logic        mem_adv,
    output logic        req_valid,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata,
    output logic [31:0] dm_out,
    output logic        mem_stall,
    output logic        addr_err_load,
    output logic        addr_err_store
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        is_load, is_store, misaligned, start, load_dm;
    logic [3:0]  op_q;
    logic [1:0]  off_q;
    logic        we_q;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata, lane, load_data;

    always_comb begin
        is_load    = (mem_op >= OP_LB) && (mem_op <= OP_LW);
        is_store   = (mem_op >= OP_SB) && (mem_op <= OP_SW);
        misaligned = (((mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH)) && mem_addr[0]) ||
                     (((mem_op == OP_LW) || (mem_op == OP_SW)) && (mem_addr[1:0] != 2'b00));
        start      = (state == S_IDLE) && mem_valid && (is_load || is_store) && !misaligned &&
                     !mem_except && !mem_flush && !rst;
    end

    assign addr_err_load  = mem_valid && is_load && misaligned;
    assign addr_err_store = mem_valid && is_store && misaligned;

    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = mem_wdata;
        case (mem_op)
            OP_SB: begin
                st_wstrb = 4'b0001 << mem_addr[1:0];
                st_wdata = {4{mem_wdata[7:0]}};
            end
            OP_SH: begin
                st_wstrb = 4'b0011 << mem_addr[1:0];
                st_wdata = {2{mem_wdata[15:0]}};
            end
            OP_SW:   st_wstrb = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        lane = resp_rdata >> {off_q, 3'b000};
        case (op_q)
            OP_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  load_data = {24'h0, lane[7:0]};
            OP_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
            OP_LHU:  load_data = {16'h0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            dm_out <= 32'h0;
        end else begin
            state <= state_nxt;
            if (load_dm) dm_out <= load_data;
        end
    end

    // Request fields are frozen at start so the bus sees them stable until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= 4'h0;
            off_q     <= 2'b00;
            we_q      <= 1'b0;
            req_addr  <= 32'h0;
            req_wdata <= 32'h0;
            req_wstrb <= 4'h0;
        end else if (start) begin
            op_q      <= mem_op;
            off_q     <= mem_addr[1:0];
            we_q      <= is_store;
            req_addr  <= {mem_addr[31:2], 2'b00};
            req_wdata <= st_wdata;
            req_wstrb <= st_wstrb;
        end
    end

    assign req_we = we_q;

    always_comb begin
        state_nxt = state;
        load_dm   = 1'b0;
        mem_stall = 1'b0;
        req_valid = 1'b0;
        case (state)
            S_IDLE: begin
                mem_stall = start;
                if (start) state_nxt = S_REQ;
            end
            S_REQ: begin
                mem_stall = 1'b1;
                req_valid = !mem_flush;
                if (mem_flush)      state_nxt = S_IDLE;
                else if (req_ready) state_nxt = we_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                if (mem_flush) begin
                    state_nxt = resp_valid ? S_IDLE : S_DRAIN;
                end else if (resp_valid) begin
                    state_nxt = S_DONE;
                    load_dm   = 1'b1;
                end
            end
            S_DRAIN: begin
                mem_stall = 1'b1;
                if (resp_valid) state_nxt = S_IDLE;
            end
            S_DONE: begin
                if (mem_adv || mem_flush) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (rst) begin
            mem_stall = 1'b0;
            req_valid = 1'b0;
            load_dm   = 1'b0;
        end
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mem_valid  in  1  valid instruction present in MEM stage.
REQ-005 mem_op  in  4  access type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none.
REQ-006 mem_addr  in  32  effective byte address.
REQ-007 mem_wdata  in  32  store source register value.
REQ-008 mem_except  in  1  upstream exception already attached to this instruction; suppresses access.
REQ-009 mem_flush  in  1  pipeline flush of MEM stage.
REQ-010 mem_adv  in  1  MEM->WB register write enable this cycle; the completed result is consumed.
REQ-011 req_valid / req_we  out  1 / 1  data-bus request; write when req_we=1.
REQ-012 req_addr / req_wdata / req_wstrb  out  32 / 32 / 4  word-aligned address {mem_addr[31:2],2'b00}; lane-replicated data; byte strobes.
REQ-013 req_ready  in  1  bus accepts request when req_valid & req_ready.
REQ-014 resp_valid / resp_rdata  in  1 / 32  read response (loads only; one response per accepted load).
REQ-015 dm_out  out  32  aligned, extended load data for MEM_DMOut.
REQ-016 mem_stall  out  1  MEM stage must hold.
REQ-017 addr_err_load / addr_err_store  out  1 / 1  misaligned load / store (AdEL / AdES).

Function
REQ-018 A start SHALL occur in IDLE when mem_valid & op in 1..8 & aligned & !mem_except & !mem_flush.
REQ-019 Misalignment: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0; the error flag SHALL be asserted combinationally while mem_valid, with no request issued and no stall.
REQ-020 States: IDLE, REQ, WAIT, DONE, DRAIN; encoded so any unreachable state returns to IDLE.
REQ-021 IDLE: on start -> REQ, capturing op, addr[1:0], req_addr, req_wdata and req_wstrb into registers; mem_stall=1 in the start cycle.
REQ-022 REQ: req_valid=1, with request fields stable until accepted; on accept, a store -> DONE and a load -> WAIT; on mem_flush before accept -> IDLE, and the request SHALL be dropped in that cycle.
REQ-023 WAIT: on resp_valid -> DONE, and dm_out SHALL be registered; on mem_flush -> DRAIN, or to IDLE if resp_valid arrives in the same cycle, with the data discarded.
REQ-024 DRAIN: on resp_valid -> IDLE with data discarded; no new request SHALL be issued from DRAIN.
REQ-025 DONE: mem_stall=0 and dm_out held; on mem_adv or mem_flush -> IDLE, and a start in the same cycle SHALL NOT be taken until IDLE.
REQ-026 mem_stall SHALL be 1 in REQ, WAIT and DRAIN; 0 in DONE; and in IDLE, 1 only on start.
REQ-027 Store strobes: SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111; data SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-028 Load extraction: lane = resp_rdata >> (8*addr[1:0]); LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through unchanged.
REQ-029 Minimum load latency SHALL be 3 cycles, start to DONE, with a same-cycle ready and a next-cycle response; a store takes 2 cycles.
REQ-030 resp_valid in IDLE, REQ or DONE SHALL be ignored.

Reset
REQ-031 rst SHALL force IDLE and req_valid=0, and set dm_out=32'h0 and mem_stall=0, regardless of state, including mid-transaction; outstanding responses after reset SHALL be ignored.

Verification
REQ-032 LB at addr 0x1003, ready same cycle, resp_rdata=0x80FF_1234 next cycle -> req_addr=0x1000, dm_out=0xFFFF_FF80, DONE after 3 cycles.
REQ-033 SH addr 0x2002, wdata=0x0000_ABCD -> req_we=1, wstrb=4'b1100, req_wdata=0xABCD_ABCD; DONE after accept; no response awaited.
REQ-034 LW addr 0x3001 -> addr_err_load=1, req_valid=0 and mem_stall=0 throughout.
REQ-035 LW accepted, mem_flush in WAIT, resp 2 cycles later -> DRAIN then IDLE; dm_out unchanged; a new LW presented during DRAIN issues only after IDLE.
REQ-036 req_ready low 3 cycles with LHU addr 0x4002 and resp 0x1234_8000 -> req_valid and fields stable for 4 cycles; dm_out=0x0000_1234.
REQ-037 rst asserted in WAIT -> next cycle IDLE, dm_out=0, stall=0; a late resp_valid is ignored.
